reorder_buffer: RTL and testbench

//  16-entry in-order reorder buffer feeding RegFile: allocates a tag per issued instruction, drives
//  the rename write (rd_in_*), and retires results in program order (rd_out_*).

---
 rtl/reorder_buffer_pkg.sv | 27 ++
 rtl/reorder_buffer_rob_ring_ctrl.sv | 66 ++++++
 rtl/reorder_buffer.sv | 167 ++++++++++++++++
 tb/tb_reorder_buffer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// Shared constants, types and helpers for the reorder buffer.
// Optional mispredict flush support is enabled by defining ROB_FLUSH_EN.
package reorder_buffer_pkg;

    localparam int ROB_AW    = 4;
    localparam int ROB_DEPTH = 1 << ROB_AW;
    localparam int RD_W      = 5;
    localparam int VAL_W     = 32;

    localparam logic [VAL_W-1:0] NULL32 = 32'h0000_0000;

    typedef logic [ROB_AW-1:0] rob_tag_t;
    typedef logic [ROB_AW:0]   rob_cnt_t;

    // Ring pointer advance; wraps naturally at ROB_DEPTH.
    function automatic rob_tag_t tag_inc(input rob_tag_t t);
        return t + rob_tag_t'(1'b1);
    endfunction

    // One-hot decode of a tag into an entry select vector, gated by en.
    function automatic logic [ROB_DEPTH-1:0] tag_sel(input logic en, input rob_tag_t t);
        logic [ROB_DEPTH-1:0] one_v;
        one_v = ROB_DEPTH'(1'b1);
        return en ? (one_v << t) : '0;
    endfunction

endpackage

// File: rtl/reorder_buffer_rob_ring_ctrl.sv
// Ring pointer control for the reorder buffer: head/tail/count,
// full/empty and issue acceptance. A commit does not free space for an
// issue in the same cycle, because acceptance looks only at the
// registered count.
module rob_ring_ctrl
    import reorder_buffer_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy_i,
    input  logic     push_req_i,
    input  logic     pop_i,
    input  logic     flush_i,
    output rob_tag_t head_o,
    output rob_tag_t tail_o,
    output logic     full_o,
    output logic     empty_o,
    output logic     push_o
);

    rob_tag_t head_q, head_d;
    rob_tag_t tail_q, tail_d;
    rob_cnt_t count_q, count_d;
    logic     full_s;
    logic     push_s;

    assign full_s  = (count_q == rob_cnt_t'(ROB_DEPTH));
    assign push_s  = rdy_i & push_req_i & ~full_s & ~flush_i;
    assign full_o  = full_s;
    assign empty_o = (count_q == rob_cnt_t'(1'b0));
    assign push_o  = push_s;
    assign head_o  = head_q;
    assign tail_o  = tail_q;

    // Next pointer/count values; a flush empties the ring outright.
    always_comb begin
        head_d = pop_i  ? tag_inc(head_q) : head_q;
        tail_d = push_s ? tag_inc(tail_q) : tail_q;
        case ({push_s, pop_i})
            2'b10:   count_d = count_q + rob_cnt_t'(1'b1);
            2'b01:   count_d = count_q - rob_cnt_t'(1'b1);
            default: count_d = count_q;
        endcase
        if (flush_i) begin
            head_d  = rob_tag_t'(1'b0);
            tail_d  = rob_tag_t'(1'b0);
            count_d = rob_cnt_t'(1'b0);
        end else begin
            count_d = count_d;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= rob_tag_t'(1'b0);
            tail_q  <= rob_tag_t'(1'b0);
            count_q <= rob_cnt_t'(1'b0);
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/reorder_buffer.sv
// 16-entry in-order reorder buffer: allocates tags at issue, drives the
// RegFile rename write, accepts CDB results, answers operand queries with
// same-cycle CDB bypass, and retires one entry per cycle in program order.
// Define ROB_FLUSH_EN to add mispredict tracking and flush-on-commit.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             issue_valid,
    input  logic [RD_W-1:0]  issue_rd,
    output logic             issue_ready,
    output rob_tag_t         issue_tag,
    input  logic             cdb_valid,
    input  rob_tag_t         cdb_tag,
    input  logic [VAL_W-1:0] cdb_val,
    input  rob_tag_t         q1_tag,
    input  rob_tag_t         q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [VAL_W-1:0] q1_val,
    output logic [VAL_W-1:0] q2_val,
    output logic             rd_in_flag,
    output logic [RD_W-1:0]  rd_in_a,
    output rob_tag_t         rd_in_rob,
    output logic             rd_out_flag,
    output logic [RD_W-1:0]  rd_out_a,
    output logic [VAL_W-1:0] rd_out_val,
    output rob_tag_t         rd_out_rob
`ifdef ROB_FLUSH_EN
    ,
    input  logic             cdb_flush,
    input  logic [VAL_W-1:0] cdb_pc,
    output logic             flush_valid,
    output logic [VAL_W-1:0] flush_pc
`endif
);

    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;
    logic [RD_W-1:0]      rd_q  [ROB_DEPTH];
    logic [RD_W-1:0]      rd_d  [ROB_DEPTH];
    logic [VAL_W-1:0]     val_q [ROB_DEPTH];
    logic [VAL_W-1:0]     val_d [ROB_DEPTH];
`ifdef ROB_FLUSH_EN
    logic [ROB_DEPTH-1:0] mispred_q, mispred_d;
    logic [VAL_W-1:0]     pc_q [ROB_DEPTH];
    logic [VAL_W-1:0]     pc_d [ROB_DEPTH];
`endif

    rob_tag_t             head_s, tail_s;
    logic                 full_s, empty_s, push_s, pop_s, wb_s, flush_s;
    logic [ROB_DEPTH-1:0] push_sel_s, pop_sel_s, wb_sel_s;
    logic                 q1_byp_s, q2_byp_s, q1_hit_s, q2_hit_s;

    // Head retires only once its result has been registered, so a CDB
    // write to the head becomes commit-eligible on the following cycle.
    assign pop_s = rdy & ~empty_s & busy_q[head_s] & done_q[head_s];
    assign wb_s  = rdy & cdb_valid & busy_q[cdb_tag];
`ifdef ROB_FLUSH_EN
    assign flush_s = pop_s & mispred_q[head_s];
`else
    assign flush_s = 1'b0;
`endif

    rob_ring_ctrl u_ring (
        .clk        (clk),
        .rst        (rst),
        .rdy_i      (rdy),
        .push_req_i (issue_valid),
        .pop_i      (pop_s),
        .flush_i    (flush_s),
        .head_o     (head_s),
        .tail_o     (tail_s),
        .full_o     (full_s),
        .empty_o    (empty_s),
        .push_o     (push_s)
    );

    assign push_sel_s = tag_sel(push_s, tail_s);
    assign pop_sel_s  = tag_sel(pop_s, head_s);
    assign wb_sel_s   = tag_sel(wb_s, cdb_tag);

    assign issue_ready = ~full_s & ~flush_s;
    assign issue_tag   = tail_s;
    assign rd_in_flag  = push_s & (issue_rd != 5'd0);
    assign rd_in_a     = issue_rd;
    assign rd_in_rob   = tail_s;
    assign rd_out_flag = pop_s;
    assign rd_out_a    = rd_q[head_s];
    assign rd_out_val  = val_q[head_s];
    assign rd_out_rob  = head_s;
`ifdef ROB_FLUSH_EN
    assign flush_valid = flush_s;
    assign flush_pc    = flush_s ? pc_q[head_s] : NULL32;
`endif

    // Operand queries: a same-cycle CDB match overrides the stored value.
    always_comb begin
        q1_byp_s = cdb_valid & (cdb_tag == q1_tag);
        q2_byp_s = cdb_valid & (cdb_tag == q2_tag);
        q1_hit_s = busy_q[q1_tag] & done_q[q1_tag];
        q2_hit_s = busy_q[q2_tag] & done_q[q2_tag];
        q1_ready = q1_byp_s | q1_hit_s;
        q2_ready = q2_byp_s | q2_hit_s;
        q1_val   = q1_byp_s ? cdb_val : (q1_hit_s ? val_q[q1_tag] : NULL32);
        q2_val   = q2_byp_s ? cdb_val : (q2_hit_s ? val_q[q2_tag] : NULL32);
    end

    // Per-entry next state: issue allocates, CDB completes, commit frees,
    // flush clears every busy bit.
    always_comb begin
        busy_d = busy_q;
        done_d = done_q;
        rd_d   = rd_q;
        val_d  = val_q;
`ifdef ROB_FLUSH_EN
        mispred_d = mispred_q;
        pc_d      = pc_q;
`endif
        for (int i = 0; i < ROB_DEPTH; i++) begin
            busy_d[i] = flush_s ? 1'b0 : push_sel_s[i] ? 1'b1 :
                        pop_sel_s[i] ? 1'b0 : busy_q[i];
            done_d[i] = push_sel_s[i] ? 1'b0 : wb_sel_s[i] ? 1'b1 : done_q[i];
            rd_d[i]   = push_sel_s[i] ? issue_rd : rd_q[i];
            val_d[i]  = push_sel_s[i] ? NULL32 : wb_sel_s[i] ? cdb_val : val_q[i];
`ifdef ROB_FLUSH_EN
            mispred_d[i] = push_sel_s[i] ? 1'b0 : wb_sel_s[i] ? cdb_flush : mispred_q[i];
            pc_d[i]      = push_sel_s[i] ? NULL32 :
                           (wb_sel_s[i] & cdb_flush) ? cdb_pc : pc_q[i];
`endif
        end
    end

    // Entry storage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            done_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rd_q[i]  <= 5'd0;
                val_q[i] <= NULL32;
            end
`ifdef ROB_FLUSH_EN
            mispred_q <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                pc_q[i] <= NULL32;
            end
`endif
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rd_q[i]  <= rd_d[i];
                val_q[i] <= val_d[i];
            end
`ifdef ROB_FLUSH_EN
            mispred_q <= mispred_d;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                pc_q[i] <= pc_d[i];
            end
`endif
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer. Expected commits are queued at
// issue time; a separate monitor pops and compares whenever rd_out_flag is
// seen. Combinational outputs are checked on the falling edge.
module tb_reorder_buffer;

    logic        clk = 1'b0;
    logic        rst, rdy, issue_valid, cdb_valid;
    logic [4:0]  issue_rd;
    logic [3:0]  cdb_tag, q1_tag, q2_tag;
    logic [31:0] cdb_val;
    logic        issue_ready, q1_ready, q2_ready, rd_in_flag, rd_out_flag;
    logic [3:0]  issue_tag, rd_in_rob, rd_out_rob;
    logic [31:0] q1_val, q2_val, rd_out_val;
    logic [4:0]  rd_in_a, rd_out_a;
`ifdef ROB_FLUSH_EN
    logic        cdb_flush, flush_valid;
    logic [31:0] cdb_pc, flush_pc;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
        logic [3:0]  rob;
    } exp_t;
    exp_t       sb[$];
    logic [3:0] exp_tail;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .q1_tag(q1_tag), .q2_tag(q2_tag),
        .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_val(q1_val), .q2_val(q2_val),
        .rd_in_flag(rd_in_flag), .rd_in_a(rd_in_a), .rd_in_rob(rd_in_rob),
        .rd_out_flag(rd_out_flag), .rd_out_a(rd_out_a),
        .rd_out_val(rd_out_val), .rd_out_rob(rd_out_rob)
`ifdef ROB_FLUSH_EN
        ,
        .cdb_flush(cdb_flush), .cdb_pc(cdb_pc),
        .flush_valid(flush_valid), .flush_pc(flush_pc)
`endif
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Commit monitor: every retirement must match the oldest queued entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && rd_out_flag) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL commit_unexpected: got rob %0d expected no commit", rd_out_rob);
                end else begin
                    e = sb.pop_front();
                    chk("commit_rd",  {27'd0, rd_out_a},   {27'd0, e.rd});
                    chk("commit_val", rd_out_val,          e.val);
                    chk("commit_rob", {28'd0, rd_out_rob}, {28'd0, e.rob});
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [31:0] v, input bit commits);
        issue_valid = 1'b1;
        issue_rd    = rd;
        @(negedge clk);
        chk("issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("issue_tag",   {28'd0, issue_tag},   {28'd0, exp_tail});
        chk("rd_in_flag",  {31'd0, rd_in_flag},  {31'd0, (rd != 5'd0)});
        chk("rd_in_a",     {27'd0, rd_in_a},     {27'd0, rd});
        chk("rd_in_rob",   {28'd0, rd_in_rob},   {28'd0, exp_tail});
        if (commits) sb.push_back({rd, v, exp_tail});
        exp_tail = exp_tail + 4'd1;
        next_cyc();
        issue_valid = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_val   = v;
        next_cyc();
        cdb_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) next_cyc();
        next_cyc();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        issue_valid = 1'b0;
        cdb_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_tail = 4'd0;
    endtask

    initial begin
        logic [3:0] t;
        rdy = 1'b1; issue_rd = 5'd0; cdb_tag = 4'd0; cdb_val = 32'd0;
        q1_tag = 4'd0; q2_tag = 4'd0;
`ifdef ROB_FLUSH_EN
        cdb_flush = 1'b0; cdb_pc = 32'd0;
`endif
        // 1: reset values, first issue, tag advance
        rst = 1'b1; issue_valid = 1'b0; cdb_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_issue_ready", {31'd0, issue_ready}, 32'd1);
        chk("rst_issue_tag",   {28'd0, issue_tag},   32'd0);
        chk("rst_rd_in_flag",  {31'd0, rd_in_flag},  32'd0);
        chk("rst_rd_out_flag", {31'd0, rd_out_flag}, 32'd0);
        chk("rst_q1_ready",    {31'd0, q1_ready},    32'd0);
        chk("rst_q2_val",      q2_val,               32'd0);
        chk("rst_rd_out_a",    {27'd0, rd_out_a},    32'd0);
        chk("rst_rd_out_val",  rd_out_val,           32'd0);
        chk("rst_rd_out_rob",  {28'd0, rd_out_rob},  32'd0);
        next_cyc();
        rst = 1'b0;
        exp_tail = 4'd0;
        issue(5'd5, 32'h1234, 1'b1);

        // 2: writeback to head commits on the next cycle, not the same one
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_val = 32'h1234;
        @(negedge clk);
        chk("tag_after_issue", {28'd0, issue_tag}, 32'd1);
        chk("wb_same_cycle_no_commit", {31'd0, rd_out_flag}, 32'd0);
        next_cyc();
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("wb_next_cycle_commit", {31'd0, rd_out_flag}, 32'd1);
        next_cyc();
        drain();

        // 3: fill to 16, reject 17th, commit frees space only afterwards
        do_reset();
        for (int i = 0; i < 16; i++) issue(5'(i + 1), 32'h100 + 32'(i), 1'b1);
        issue_valid = 1'b1; issue_rd = 5'd31;
        @(negedge clk);
        chk("full_issue_ready", {31'd0, issue_ready}, 32'd0);
        chk("full_rd_in_flag",  {31'd0, rd_in_flag},  32'd0);
        next_cyc();
        issue_valid = 1'b0;
        cdb(4'd0, 32'h100);
        issue_valid = 1'b1; issue_rd = 5'd30;
        @(negedge clk);
        chk("commit_cycle_still_full", {31'd0, issue_ready}, 32'd0);
        chk("commit_cycle_no_issue",   {31'd0, rd_in_flag},  32'd0);
        chk("commit_cycle_flag",       {31'd0, rd_out_flag}, 32'd1);
        next_cyc();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("slot_freed", {31'd0, issue_ready}, 32'd1);
        next_cyc();
        for (int i = 1; i < 16; i++) cdb(4'(i), 32'h100 + 32'(i));
        drain();

        // 4: wrap-around, including x0 destinations
        for (int i = 0; i < 20; i++) begin
            t = exp_tail;
            issue(5'((i * 3) % 8), 32'hA000 + 32'(i), 1'b1);
            cdb(t, 32'hA000 + 32'(i));
        end
        drain();

        // 5: query bypass versus unwritten entry
        do_reset();
        q1_tag = 4'd3;
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_val = 32'hBEEF;
        @(negedge clk);
        chk("q1_bypass_ready", {31'd0, q1_ready}, 32'd1);
        chk("q1_bypass_val",   q1_val,            32'hBEEF);
        next_cyc();
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("q1_unwritten_ready", {31'd0, q1_ready}, 32'd0);
        chk("q1_unwritten_val",   q1_val,            32'd0);
        next_cyc();
        issue(5'd7, 32'h55, 1'b1);
        q2_tag = 4'd0;
        cdb_valid = 1'b1; cdb_tag = 4'd0; cdb_val = 32'h55;
        @(negedge clk);
        chk("q2_bypass_val", q2_val, 32'h55);
        next_cyc();
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("q2_stored_ready", {31'd0, q2_ready}, 32'd1);
        chk("q2_stored_val",   q2_val,            32'h55);
        next_cyc();

        // rdy low freezes commit and issue but queries still answer
        issue(5'd9, 32'h99, 1'b1);
        cdb(4'd1, 32'h99);
        rdy = 1'b0; issue_valid = 1'b1; issue_rd = 5'd12; q2_tag = 4'd1;
        @(negedge clk);
        chk("rdy_low_no_commit", {31'd0, rd_out_flag}, 32'd0);
        chk("rdy_low_no_rename", {31'd0, rd_in_flag},  32'd0);
        chk("rdy_low_query_val", q2_val,               32'h99);
        next_cyc();
        issue_valid = 1'b0; rdy = 1'b1;
        @(negedge clk);
        chk("rdy_high_commit",   {31'd0, rd_out_flag}, 32'd1);
        chk("rdy_low_tag_held",  {28'd0, issue_tag},   {28'd0, exp_tail});
        next_cyc();
        drain();

`ifdef ROB_FLUSH_EN
        // 6: mispredicted entry flushes the buffer when it commits
        do_reset();
        issue(5'd1, 32'h11, 1'b1);
        issue(5'd2, 32'h22, 1'b1);
        issue(5'd3, 32'h33, 1'b0);
        issue(5'd4, 32'h44, 1'b0);
        cdb_flush = 1'b1; cdb_pc = 32'h100;
        cdb(4'd1, 32'h22);
        cdb_flush = 1'b0;
        cdb(4'd0, 32'h11);
        @(negedge clk);
        chk("no_flush_on_good", {31'd0, flush_valid}, 32'd0);
        next_cyc();
        @(negedge clk);
        chk("flush_valid",        {31'd0, flush_valid}, 32'd1);
        chk("flush_pc",           flush_pc,             32'h100);
        chk("flush_issue_ready",  {31'd0, issue_ready}, 32'd0);
        next_cyc();
        exp_tail = 4'd0;
        @(negedge clk);
        chk("post_flush_ready", {31'd0, issue_ready}, 32'd1);
        chk("post_flush_tag",   {28'd0, issue_tag},   32'd0);
        cdb(4'd2, 32'h33);
        @(negedge clk);
        chk("post_flush_empty", {31'd0, rd_out_flag}, 32'd0);
        next_cyc();
        drain();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
